// File: rtl/sm2201_camac_bridge.sv
// SM2201 ISA-to-CAMAC bridge: an 8-byte ISA I/O window that drives a single-cycle
// CAMAC master (address/data registers, command start, status, read-back data).
module sm2201_camac_bridge #(
    parameter logic [9:0] BASE_ADDR   = 10'h100,
    parameter int         ACK_TIMEOUT = 255
) (
    input  logic        isa_clk,
    input  logic        isa_reset,
    input  logic        isa_ior,
    input  logic        isa_iow,
    input  logic [9:0]  isa_addr,
    inout  wire  [7:0]  isa_data,
    input  logic        isa_ale,
    input  logic        isa_aen,
    output logic        isa_chrdy,
    output logic        q_r_debug,
    input  logic        cb_prr,
    input  logic        cb_zk4,
    input  logic        cb_cx1,
    inout  wire  [15:0] cb_data,
    output logic [11:0] cb_addr,
    output logic        cb_b_b1
);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, LATCH} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [9:0]  lat_addr;
    logic [9:0]  offs;
    logic [2:0]  sel;
    logic        hit;
    logic        rd_en;
    logic        iow_prev;
    logic        wr_stb;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [11:0] addr_reg;
    logic        dir;
    logic        timeout;
    logic        x_resp;
    logic [15:0] wait_cnt;
    logic        b_b1;
    logic        busy;
    logic [7:0]  status;
    logic [7:0]  rd_val;

    // Modular offset makes the window check independent of BASE_ADDR alignment.
    assign offs   = lat_addr - BASE_ADDR;
    assign hit    = !isa_aen && (offs[9:3] == 7'd0);
    assign sel    = offs[2:0];
    assign busy   = (state != IDLE);
    assign wr_stb = hit && !isa_iow && iow_prev;
    assign rd_en  = hit && !isa_ior;
    assign status = {3'b000, timeout, x_resp, busy, ~cb_zk4, ~cb_prr};

    always_comb begin
        rd_val = 8'h00;
        case (sel)
            3'd0:    rd_val = wdata[7:0];
            3'd1:    rd_val = wdata[15:8];
            3'd2:    rd_val = addr_reg[7:0];
            3'd3:    rd_val = {4'b0000, addr_reg[11:8]};
            3'd4:    rd_val = rdata[7:0];
            3'd5:    rd_val = rdata[15:8];
            3'd6:    rd_val = status;
            default: rd_val = 8'h00;
        endcase
    end

    assign isa_data  = rd_en ? rd_val : 8'bz;
    assign q_r_debug = !rd_en;
    assign isa_chrdy = !(busy && hit && (!isa_ior || !isa_iow));
    assign cb_addr   = addr_reg;
    assign cb_b_b1   = b_b1;
    assign cb_data   = b_b1 ? 16'bz : wdata;

    always_ff @(posedge isa_clk or posedge isa_reset) begin
        if (isa_reset) begin
            state    <= IDLE;
            lat_addr <= 10'd0;
            iow_prev <= 1'b1;
            wdata    <= 16'h0000;
            rdata    <= 16'h0000;
            addr_reg <= 12'h000;
            dir      <= 1'b0;
            timeout  <= 1'b0;
            x_resp   <= 1'b0;
            wait_cnt <= 16'h0000;
            b_b1     <= 1'b1;
        end else begin
            iow_prev <= isa_iow;
            if (isa_ale)
                lat_addr <= isa_addr;

            if (wr_stb) begin
                case (sel)
                    3'd0: wdata[7:0]      <= isa_data;
                    3'd1: wdata[15:8]     <= isa_data;
                    3'd2: addr_reg[7:0]   <= isa_data;
                    3'd3: addr_reg[11:8]  <= isa_data[3:0];
                    3'd7: begin
                        // A command while a cycle is in flight is dropped.
                        if (state == IDLE) begin
                            dir     <= isa_data[0];
                            timeout <= 1'b0;
                            x_resp  <= 1'b0;
                            b_b1    <= isa_data[0];
                            state   <= SETUP;
                        end
                    end
                    default: ;
                endcase
            end

            case (state)
                SETUP: begin
                    wait_cnt <= 16'h0000;
                    state    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!cb_prr) begin
                        state <= LATCH;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout <= 1'b1;
                        b_b1    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                LATCH: begin
                    if (dir)
                        rdata <= cb_data;
                    x_resp <= ~cb_cx1;
                    b_b1   <= 1'b1;
                    state  <= IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm2201_camac_bridge.sv
// Bench for sm2201_camac_bridge: ISA host tasks plus a register/cycle-level reference model.
module tb_sm2201_camac_bridge;

    localparam logic [9:0] BASE = 10'h100;
    localparam int         TMO  = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ior, iow, ale, aen, prr, zk4, cx1;
    logic [9:0]  addr;
    logic        isa_drv, cb_drv;
    logic [7:0]  isa_val;
    logic [15:0] cb_val;
    wire  [7:0]  isa_data;
    wire  [15:0] cb_data;
    wire         chrdy, qr, bb1;
    wire  [11:0] cba;

    assign isa_data = isa_drv ? isa_val : 8'bz;
    assign cb_data  = (cb_drv && bb1) ? cb_val : 16'bz;

    sm2201_camac_bridge #(.BASE_ADDR(BASE), .ACK_TIMEOUT(TMO)) dut (
        .isa_clk(clk), .isa_reset(rst), .isa_ior(ior), .isa_iow(iow),
        .isa_addr(addr), .isa_data(isa_data), .isa_ale(ale), .isa_aen(aen),
        .isa_chrdy(chrdy), .q_r_debug(qr), .cb_prr(prr), .cb_zk4(zk4),
        .cb_cx1(cx1), .cb_data(cb_data), .cb_addr(cba), .cb_b_b1(bb1)
    );

    int pass_cnt = 0;
    int total    = 0;

    // Reference model of the host-visible register file.
    logic [15:0] m_wdata, m_rdata;
    logic [11:0] m_addr;
    logic        m_to, m_xr;

    task automatic model_reset();
        m_wdata = 16'h0; m_rdata = 16'h0; m_addr = 12'h0; m_to = 1'b0; m_xr = 1'b0;
    endtask

    task automatic model_write(input int o, input logic [7:0] d);
        case (o)
            0: m_wdata[7:0]   = d;
            1: m_wdata[15:8]  = d;
            2: m_addr[7:0]    = d;
            3: m_addr[11:8]   = d[3:0];
            default: ;
        endcase
    endtask

    function automatic logic [7:0] model_read(input int o);
        case (o)
            0: return m_wdata[7:0];
            1: return m_wdata[15:8];
            2: return m_addr[7:0];
            3: return {4'h0, m_addr[11:8]};
            4: return m_rdata[7:0];
            5: return m_rdata[15:8];
            6: return {3'b000, m_to, m_xr, 1'b0, ~zk4, ~prr};
            default: return 8'h00;
        endcase
    endfunction

    // Clock (counted from the command edge) on which the bench first sees the block idle.
    function automatic int model_idle_clock(input int p);
        int ack_clk;
        ack_clk = ((p < 1) ? 1 : p) + 1;
        if (ack_clk > 1 + TMO) return 1 + TMO;
        return ack_clk + 1;
    endfunction

    task automatic model_cycle(input logic d, input int p, input logic [15:0] cdata, input logic cx);
        m_to = (((p < 1) ? 1 : p) + 1) > (1 + TMO);
        m_xr = m_to ? 1'b0 : ~cx;
        if (d && !m_to) m_rdata = cdata;
    endtask

    task automatic latch(input int o);
        @(negedge clk); ale = 1'b1; addr = BASE + 10'(o);
        @(negedge clk); ale = 1'b0;
    endtask

    task automatic isa_wr(input int o, input logic [7:0] d);
        latch(o);
        isa_val = d; isa_drv = 1'b1; iow = 1'b0;
        @(negedge clk); iow = 1'b1; isa_drv = 1'b0;
    endtask

    task automatic isa_rd(input int o, output logic [7:0] d, output logic q);
        latch(o);
        ior = 1'b0;
        #2; d = isa_data; q = qr;
        @(negedge clk); ior = 1'b1;
    endtask

    // Issues a command and polls STATUS every clock until idle, collecting observations.
    task automatic run_cycle(input logic d, input int p, input logic [15:0] cdata, input logic cx,
                             output int idle_n, output int drv_err, output int rdy_err,
                             output logic [7:0] st_last);
        logic [7:0] st;
        prr = (p <= 0) ? 1'b0 : 1'b1; cx1 = cx; cb_val = cdata; cb_drv = d;
        latch(7);
        isa_val = {7'b0, d}; isa_drv = 1'b1; iow = 1'b0;
        @(negedge clk); iow = 1'b1; isa_drv = 1'b0; ale = 1'b1; addr = BASE + 10'd6;
        @(negedge clk); ale = 1'b0; ior = 1'b0;
        idle_n = -1; drv_err = 0; rdy_err = 0; st_last = 8'hxx;
        for (int n = 1; n <= 400; n++) begin
            if (n >= p) prr = 1'b0;
            #2; st = isa_data;
            if (st[2]) begin
                if (!d && (bb1 !== 1'b0 || cb_data !== m_wdata)) drv_err++;
                if (d && bb1 !== 1'b1) drv_err++;
                if (chrdy !== 1'b0) rdy_err++;
            end else begin
                idle_n = n; st_last = st;
                if (bb1 !== 1'b1) drv_err++;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk); ior = 1'b1; cb_drv = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d; logic q;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (qr !== 1'b1) $display("FAIL reset_qr: got %b want 1", qr); else pass_cnt++;
        total++; if (chrdy !== 1'b1) $display("FAIL reset_chrdy: got %b want 1", chrdy); else pass_cnt++;
        total++; if (bb1 !== 1'b1) $display("FAIL reset_bb1: got %b want 1", bb1); else pass_cnt++;
        total++; if (cba !== 12'h000) $display("FAIL reset_cb_addr: got %h want 000", cba); else pass_cnt++;
        rst = 1'b0;
        model_reset();
        for (int o = 0; o < 8; o++) begin
            isa_rd(o, d, q);
            total++;
            if (d !== model_read(o) || q !== 1'b0)
                $display("FAIL reset_reg%0d: got %h/q%b want %h/q0", o, d, q, model_read(o));
            else pass_cnt++;
        end
    endtask

    task automatic test_passivity();
        int bad_q = 0, bad_r = 0;
        logic [7:0] d; logic q;
        aen = 1'b1;
        latch(6);
        isa_val = 8'h00; isa_drv = 1'b1; ior = 1'b0;
        repeat (100) begin
            @(negedge clk); #2;
            if (qr !== 1'b1) bad_q++;
            if (chrdy !== 1'b1) bad_r++;
        end
        total++; if (isa_data !== 8'h00) $display("FAIL dma_ext_read: got %h want 00", isa_data); else pass_cnt++;
        ior = 1'b1; isa_drv = 1'b0;
        total++; if (bad_q != 0) $display("FAIL dma_qr: got %0d driven clocks want 0", bad_q); else pass_cnt++;
        total++; if (bad_r != 0) $display("FAIL dma_chrdy: got %0d wait clocks want 0", bad_r); else pass_cnt++;
        isa_wr(2, 8'h77);
        aen = 1'b0;
        isa_rd(2, d, q);
        total++; if (d !== model_read(2)) $display("FAIL dma_no_write: got %h want %h", d, model_read(2)); else pass_cnt++;
    endtask

    task automatic test_status();
        logic [7:0] d; logic q;
        isa_rd(6, d, q);
        total++; if (d !== 8'h00 || q !== 1'b0) $display("FAIL status_idle: got %h/q%b want 00/q0", d, q); else pass_cnt++;
        zk4 = 1'b0;
        isa_rd(6, d, q);
        total++; if (d !== 8'h02) $display("FAIL status_lam: got %h want 02", d); else pass_cnt++;
        prr = 1'b0;
        isa_rd(6, d, q);
        total++; if (d !== 8'h03) $display("FAIL status_prr: got %h want 03", d); else pass_cnt++;
        zk4 = 1'b1; prr = 1'b1;
    endtask

    task automatic test_loopback();
        logic [7:0] d, v; logic q; int o;
        isa_wr(2, 8'hA5); model_write(2, 8'hA5);
        isa_wr(3, 8'h0C); model_write(3, 8'h0C);
        total++; if (cba !== 12'hCA5) $display("FAIL loop_cb_addr: got %h want CA5", cba); else pass_cnt++;
        isa_rd(2, d, q);
        total++; if (d !== 8'hA5) $display("FAIL loop_rd2: got %h want A5", d); else pass_cnt++;
        isa_rd(3, d, q);
        total++; if (d !== 8'h0C) $display("FAIL loop_rd3: got %h want 0C", d); else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            o = $urandom_range(0, 6);
            v = 8'($urandom);
            isa_wr(o, v); model_write(o, v);
            o = $urandom_range(0, 7);
            isa_rd(o, d, q);
            total++; if (d !== model_read(o)) $display("FAIL loop_rand_reg%0d: got %h want %h", o, d, model_read(o)); else pass_cnt++;
            total++; if (cba !== m_addr) $display("FAIL loop_rand_cb_addr: got %h want %h", cba, m_addr); else pass_cnt++;
        end
    endtask

    task automatic test_camac_write();
        int idle_n, de, re; logic [7:0] st, exp_st;
        isa_wr(0, 8'h34); model_write(0, 8'h34);
        isa_wr(1, 8'h12); model_write(1, 8'h12);
        run_cycle(1'b0, 5, 16'h0000, 1'b1, idle_n, de, re, st);
        model_cycle(1'b0, 5, 16'h0000, 1'b1);
        exp_st = model_read(6);
        total++; if (idle_n != model_idle_clock(5)) $display("FAIL wr_busy_len: got %0d want %0d", idle_n, model_idle_clock(5)); else pass_cnt++;
        total++; if (de != 0) $display("FAIL wr_bus_drive: got %0d bad clocks want 0", de); else pass_cnt++;
        total++; if (re != 0) $display("FAIL wr_chrdy: got %0d bad clocks want 0", re); else pass_cnt++;
        total++; if (st !== exp_st) $display("FAIL wr_status: got %h want %h", st, exp_st); else pass_cnt++;
        prr = 1'b1;
    endtask

    task automatic test_camac_read();
        int idle_n, de, re; logic [7:0] st, d, exp_st; logic q;
        run_cycle(1'b1, 0, 16'hBEEF, 1'b0, idle_n, de, re, st);
        model_cycle(1'b1, 0, 16'hBEEF, 1'b0);
        exp_st = model_read(6);
        total++; if (idle_n != 3) $display("FAIL rd_min_len: got %0d want 3", idle_n); else pass_cnt++;
        total++; if (de != 0 || re != 0) $display("FAIL rd_bus: got %0d/%0d bad clocks want 0/0", de, re); else pass_cnt++;
        total++; if (st !== exp_st) $display("FAIL rd_status: got %h want %h", st, exp_st); else pass_cnt++;
        prr = 1'b1;
        isa_rd(4, d, q);
        total++; if (d !== 8'hEF) $display("FAIL rd_lo: got %h want EF", d); else pass_cnt++;
        isa_rd(5, d, q);
        total++; if (d !== 8'hBE) $display("FAIL rd_hi: got %h want BE", d); else pass_cnt++;
        isa_rd(6, d, q);
        total++; if (d !== 8'h08) $display("FAIL rd_xresp: got %h want 08", d); else pass_cnt++;
    endtask

    task automatic test_cmd_while_busy();
        logic [7:0] d; logic q; int seen;
        logic c;
        c = 1'($urandom);
        cx1 = c; prr = 1'b1;
        isa_wr(0, 8'h5C); model_write(0, 8'h5C);
        isa_wr(7, 8'h00);
        isa_wr(7, 8'h01);
        @(negedge clk); #2;
        total++;
        if (bb1 !== 1'b0 || cb_data !== m_wdata) $display("FAIL busy_cmd_ignored: got bb1=%b data=%h want 0/%h", bb1, cb_data, m_wdata);
        else pass_cnt++;
        prr = 1'b0;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #2;
            if (bb1 === 1'b1) begin seen = 1; break; end
        end
        total++; if (seen != 1) $display("FAIL busy_release: got bb1=%b want 1 within 20 clocks", bb1); else pass_cnt++;
        model_cycle(1'b0, 1, 16'h0000, c);
        isa_rd(6, d, q);
        total++; if (d !== model_read(6)) $display("FAIL busy_status: got %h want %h", d, model_read(6)); else pass_cnt++;
        isa_rd(4, d, q);
        total++; if (d !== model_read(4)) $display("FAIL busy_rdata: got %h want %h", d, model_read(4)); else pass_cnt++;
        prr = 1'b1;
    endtask

    task automatic test_back_to_back();
        int idle_n, de, re, p; logic [7:0] st, d, exp_st; logic q, dr, c; logic [15:0] cd;
        for (int i = 0; i < 8; i++) begin
            isa_wr(0, 8'($urandom)); model_write(0, dut_byte(0));
            isa_wr(1, 8'($urandom)); model_write(1, dut_byte(1));
            dr = 1'($urandom); p = $urandom_range(0, 8); cd = 16'($urandom); c = 1'($urandom);
            run_cycle(dr, p, cd, c, idle_n, de, re, st);
            model_cycle(dr, p, cd, c);
            exp_st = model_read(6);
            total++; if (idle_n != model_idle_clock(p)) $display("FAIL b2b_len%0d: got %0d want %0d", i, idle_n, model_idle_clock(p)); else pass_cnt++;
            total++; if (de != 0 || re != 0) $display("FAIL b2b_bus%0d: got %0d/%0d want 0/0", i, de, re); else pass_cnt++;
            total++; if (st !== exp_st) $display("FAIL b2b_status%0d: got %h want %h", i, st, exp_st); else pass_cnt++;
            prr = 1'b1;
            isa_rd(5, d, q);
            total++; if (d !== model_read(5)) $display("FAIL b2b_rdata%0d: got %h want %h", i, d, model_read(5)); else pass_cnt++;
        end
    endtask

    // Last byte the bench itself drove for a write (keeps the model fed from stimulus, not the DUT).
    function automatic logic [7:0] dut_byte(input int o);
        return (o >= 0) ? isa_val : 8'h00;
    endfunction

    task automatic test_timeout();
        int idle_n, de, re; logic [7:0] st, d; logic q;
        run_cycle(1'b1, 100000, 16'h1111, 1'b0, idle_n, de, re, st);
        model_cycle(1'b1, 100000, 16'h1111, 1'b0);
        total++; if (idle_n != 1 + TMO) $display("FAIL tmo_len: got %0d want %0d", idle_n, 1 + TMO); else pass_cnt++;
        total++; if (st !== 8'h10) $display("FAIL tmo_status: got %h want 10", st); else pass_cnt++;
        isa_rd(4, d, q);
        total++; if (d !== model_read(4)) $display("FAIL tmo_rdata_kept: got %h want %h", d, model_read(4)); else pass_cnt++;
        isa_wr(2, 8'h3B); model_write(2, 8'h3B);
        prr = 1'b1;
        isa_wr(7, 8'h00);
        repeat (10) @(negedge clk);
        total++; if (bb1 !== 1'b0) $display("FAIL tmo_pre_reset_drive: got %b want 0", bb1); else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total++; if (bb1 !== 1'b1) $display("FAIL async_reset_bb1: got %b want 1", bb1); else pass_cnt++;
        total++; if (cba !== 12'h000) $display("FAIL async_reset_cb_addr: got %h want 000", cba); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        model_reset();
        isa_rd(6, d, q);
        total++; if (d !== 8'h00) $display("FAIL post_reset_status: got %h want 00", d); else pass_cnt++;
        isa_rd(0, d, q);
        total++; if (d !== 8'h00) $display("FAIL post_reset_wdata: got %h want 00", d); else pass_cnt++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ior = 1'b1; iow = 1'b1; ale = 1'b0; aen = 1'b0; addr = 10'h0;
        prr = 1'b1; zk4 = 1'b1; cx1 = 1'b1;
        isa_drv = 1'b0; isa_val = 8'h00; cb_drv = 1'b0; cb_val = 16'h0;
        model_reset();
        test_reset();
        test_passivity();
        test_status();
        test_loopback();
        test_camac_write();
        test_camac_read();
        test_cmd_while_busy();
        test_back_to_back();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
